// File: rtl/framebuffer_write_arbiter_if.sv
// framebuffer_write_arbiter_if
//   Bundles the two requester handshakes, the clear-engine controls and the
//   framebuffer write port. The clock and reset stay as plain module ports.
//
//   Signals:
//     req0_valid/ready/address/data  requester 0 handshake
//     req1_valid/ready/address/data  requester 1 handshake
//     clear_start, clear_color       clear-engine start pulse and fill value
//     clear_busy, addr_error         clear status and sticky range-error flag
//     write_signal/address/data      registered framebuffer write port
//
//   Modports:
//     master  the writer side (requesters, clear control, framebuffer)
//     slave   the arbiter
interface framebuffer_write_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  clear_start;
  logic [DATA_WIDTH-1:0] clear_color;
  logic                  clear_busy;
  logic                  addr_error;

  logic                  write_signal;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output req0_valid, req0_address, req0_data,
    output req1_valid, req1_address, req1_data,
    output clear_start, clear_color,
    input  req0_ready, req1_ready,
    input  clear_busy, addr_error,
    input  write_signal, write_address, write_data
  );

  modport slave (
    input  req0_valid, req0_address, req0_data,
    input  req1_valid, req1_address, req1_data,
    input  clear_start, clear_color,
    output req0_ready, req1_ready,
    output clear_busy, addr_error,
    output write_signal, write_address, write_data
  );
endinterface

// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
//   Shares the single framebuffer write port between two requesters with
//   round-robin arbitration, and provides a clear engine that fills every
//   location 0..FB_WORDS-1 with one color. Readies are combinational; the
//   write port is registered, so an accepted request is written one cycle
//   later. Requests aimed past the end of the framebuffer are accepted but
//   dropped, and raise a sticky addr_error.
//
//   Ports:
//     vga_clock  sole clock, posedge
//     reset_n    asynchronous active-low reset
//     bus        framebuffer_write_arbiter_if.slave (requests, clear, write port)
//
//   ADDR_WIDTH/DATA_WIDTH must match the parameters of the connected interface.
module framebuffer_write_arbiter #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8,
  parameter int FB_WORDS   = 307200
) (
  input  logic                         vga_clock,
  input  logic                         reset_n,
  framebuffer_write_arbiter_if.slave   bus
);

  // One extra bit so FB_WORDS == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   FB_LIMIT  = (ADDR_WIDTH + 1)'(FB_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WORDS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  state_t                next_state;
  logic                  rr_ptr;        // requester favoured on a tie
  logic [ADDR_WIDTH-1:0] counter;       // next clear address
  logic [DATA_WIDTH-1:0] color;         // fill value latched at clear_start

  logic                  grant0;
  logic                  grant1;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] grant_address;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_in_range;

  logic                  write_signal_q;
  logic [ADDR_WIDTH-1:0] write_address_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic                  clear_busy_q;
  logic                  addr_error_q;

  // Next-state and grant decode.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        // A clear start takes the cycle; neither requester is granted.
        if (bus.clear_start) begin
          next_state = CLEAR;
        end else if (bus.req0_valid && bus.req1_valid) begin
          grant0 = ~rr_ptr;
          grant1 = rr_ptr;
        end else begin
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid;
        end
      end
      CLEAR: begin
        if (counter == LAST_ADDR) next_state = IDLE;
      end
    endcase
  end

  assign grant_any      = grant0 | grant1;
  assign grant_address  = grant1 ? bus.req1_address : bus.req0_address;
  assign grant_data     = grant1 ? bus.req1_data    : bus.req0_data;
  assign grant_in_range = {1'b0, grant_address} < FB_LIMIT;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      counter         <= '0;
      color           <= '0;
      write_signal_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      clear_busy_q    <= 1'b0;
      addr_error_q    <= 1'b0;
    end else begin
      state          <= next_state;
      write_signal_q <= 1'b0;
      case (state)
        IDLE: begin
          clear_busy_q <= bus.clear_start;
          if (bus.clear_start) begin
            color   <= bus.clear_color;
            counter <= '0;
          end else if (grant_any) begin
            // The other requester is favoured after any grant, even a dropped one.
            rr_ptr <= grant0;
            if (grant_in_range) begin
              write_signal_q  <= 1'b1;
              write_address_q <= grant_address;
              write_data_q    <= grant_data;
            end else begin
              addr_error_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // Busy stays up until the cycle the last address is on the port.
          clear_busy_q    <= 1'b1;
          write_signal_q  <= 1'b1;
          write_address_q <= counter;
          write_data_q    <= color;
          if (counter != LAST_ADDR) counter <= counter + ADDR_WIDTH'(1);
        end
      endcase
    end
  end

  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.write_signal  = write_signal_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.clear_busy    = clear_busy_q;
  assign bus.addr_error    = addr_error_q;

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// tb_framebuffer_write_arbiter
//   Self-checking bench for framebuffer_write_arbiter. The framebuffer size is
//   reduced to 2048 words so full clears stay short; all rules scale with it.
module tb_framebuffer_write_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int W  = 2048;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  framebuffer_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  framebuffer_write_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .FB_WORDS  (W)
  ) dut (
    .vga_clock(clk),
    .reset_n  (rst_n),
    .bus      (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational readies settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic cs, input logic [DW-1:0] cc);
    bus.req0_valid   = v0;
    bus.req0_address = a0;
    bus.req0_data    = d0;
    bus.req1_valid   = v1;
    bus.req1_address = a1;
    bus.req1_data    = d1;
    bus.clear_start  = cs;
    bus.clear_color  = cc;
  endtask

  task automatic drive_idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          ws;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } vec_t;

  function automatic vec_t mk(input logic v0, input int a0, input int d0,
                              input logic v1, input int a1, input int d1,
                              input logic r0, input logic r1,
                              input logic ws, input int wa, input int wd);
    vec_t v;
    v.v0 = v0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.v1 = v1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.r0 = r0; v.r1 = r1;
    v.ws = ws; v.wa = AW'(wa); v.wd = DW'(wd);
    return v;
  endfunction

  vec_t vecs[12];

  // Behavioural model state for the random phase.
  int            m_rr;
  bit            m_err;
  bit            m_in_clear;
  int            m_idx;
  logic [DW-1:0] m_color;

  initial begin
    int blocked, writes, bad, expect_idx;
    bit pulse, granted, found;

    // Reset values; the address after grant 1 favours req0 first.
    vecs[0]  = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
    vecs[1]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
    vecs[2]  = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
    vecs[3]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
    vecs[4]  = mk(1, 1, 'h11, 1, 2, 'h22, 1, 0, 1, 1, 'h11);
    vecs[5]  = mk(1, 1, 'h11, 1, 2, 'h22, 0, 1, 1, 2, 'h22);
    vecs[6]  = mk(1, 'h10, 'hA5, 0, 0, 0, 1, 0, 1, 'h10, 'hA5);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h10, 'hA5);
    vecs[8]  = mk(0, 0, 0, 1, 3, 'h33, 0, 1, 1, 3, 'h33);
    vecs[9]  = mk(1, 4, 'h44, 1, 6, 'h66, 1, 0, 1, 4, 'h44);
    vecs[10] = mk(1, 4, 'h44, 1, 6, 'h66, 0, 1, 1, 6, 'h66);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 'h66);

    // ---------------- reset state ----------------
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_write_signal", 32'(bus.write_signal), 0);
    check("rst_write_address", 32'(bus.write_address), 0);
    check("rst_write_data", 32'(bus.write_data), 0);
    check("rst_clear_busy", 32'(bus.clear_busy), 0);
    check("rst_addr_error", 32'(bus.addr_error), 0);
    rst_n = 1'b1;
    tick();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, 1'b0, '0);
      settle();
      check($sformatf("vec%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      check($sformatf("vec%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      tick();
      check($sformatf("vec%0d_write_signal", i), 32'(bus.write_signal), 32'(vecs[i].ws));
      check($sformatf("vec%0d_write_address", i), 32'(bus.write_address), 32'(vecs[i].wa));
      check($sformatf("vec%0d_write_data", i), 32'(bus.write_data), 32'(vecs[i].wd));
    end

    // ---------------- full clear with req1 waiting ----------------
    drive(1'b0, '0, '0, 1'b1, AW'(9), 8'h99, 1'b1, 8'h3C);
    settle();
    check("clr_start_req1_ready", 32'(bus.req1_ready), 0);
    tick();
    bus.clear_start = 1'b0;
    check("clr_busy_rise", 32'(bus.clear_busy), 1);
    check("clr_first_no_write", 32'(bus.write_signal), 0);
    blocked = 0; writes = 0; bad = 0; expect_idx = 0; pulse = 0; granted = 0;
    for (int k = 0; k < W + 20 && !granted; k++) begin
      bus.clear_start = pulse;
      if (pulse) bus.clear_color = 8'hFF;   // color change mid-clear must not matter
      pulse = 0;
      settle();
      if (bus.req1_ready) begin
        granted = 1;
        tick();
        check("clr_req1_write_signal", 32'(bus.write_signal), 1);
        check("clr_req1_write_address", 32'(bus.write_address), 9);
        check("clr_req1_write_data", 32'(bus.write_data), 'h99);
        check("clr_busy_fall", 32'(bus.clear_busy), 0);
      end else begin
        blocked++;
        tick();
        if (bus.write_signal) begin
          if (bus.write_address != AW'(expect_idx) || bus.write_data != 8'h3C) bad++;
          if (bus.write_address == AW'(1000)) pulse = 1;
          if (bus.write_address == AW'(W - 1))
            check("clr_busy_last_addr", 32'(bus.clear_busy), 1);
          expect_idx++;
          writes++;
        end
      end
    end
    check("clr_req1_granted", 32'(granted), 1);
    check("clr_blocked_cycles", 32'(blocked), W);
    check("clr_write_count", 32'(writes), W);
    check("clr_bad_writes", 32'(bad), 0);
    drive_idle();
    tick();
    check("clr_after_idle", 32'(bus.write_signal), 0);

    // ---------------- out-of-range request ----------------
    drive(1'b1, AW'(W), 8'h01, 1'b0, '0, '0, 1'b0, '0);
    settle();
    check("oor_req0_ready", 32'(bus.req0_ready), 1);
    tick();
    check("oor_no_write", 32'(bus.write_signal), 0);
    check("oor_addr_error", 32'(bus.addr_error), 1);
    drive_idle();
    tick();
    check("oor_error_sticky", 32'(bus.addr_error), 1);
    drive(1'b1, AW'(5), 8'h55, 1'b0, '0, '0, 1'b0, '0);
    settle();
    check("oor_legal_ready", 32'(bus.req0_ready), 1);
    tick();
    check("oor_legal_write_signal", 32'(bus.write_signal), 1);
    check("oor_legal_write_address", 32'(bus.write_address), 5);
    check("oor_legal_write_data", 32'(bus.write_data), 'h55);
    check("oor_legal_error_kept", 32'(bus.addr_error), 1);

    // ---------------- reset in the middle of a clear ----------------
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 8'h77);
    tick();
    bus.clear_start = 1'b0;
    found = 0;
    for (int k = 0; k < W + 10 && !found; k++) begin
      tick();
      if (bus.write_signal && bus.write_address == AW'(500)) found = 1;
    end
    check("rmc_reached_500", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmc_write_signal", 32'(bus.write_signal), 0);
    check("rmc_clear_busy", 32'(bus.clear_busy), 0);
    check("rmc_addr_error", 32'(bus.addr_error), 0);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, AW'(7), 8'h70, 1'b0, '0);
    settle();
    check("rmc_req1_ready", 32'(bus.req1_ready), 1);
    tick();
    check("rmc_write_signal_after", 32'(bus.write_signal), 1);
    check("rmc_write_address_after", 32'(bus.write_address), 7);
    check("rmc_write_data_after", 32'(bus.write_data), 'h70);
    drive_idle();
    tick();
    check("rmc_no_clear_resume", 32'(bus.write_signal), 0);
    check("rmc_busy_stays_low", 32'(bus.clear_busy), 0);

    // ---------------- randomized run against the model ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_rr = 0; m_err = 0; m_in_clear = 0; m_idx = 0; m_color = '0;
    begin
      bit            p0v, p1v;
      logic [AW-1:0] p0a, p1a;
      logic [DW-1:0] p0d, p1d;
      logic          cs;
      logic [DW-1:0] cc;
      bit            exp_r0, exp_r1, exp_ws, exp_busy;
      logic [AW-1:0] exp_wa;
      logic [DW-1:0] exp_wd;
      int            who;
      p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
      for (int c = 0; c < 5000; c++) begin
        if (!p0v && $urandom_range(0, 9) < 6) begin
          p0v = 1;
          p0a = ($urandom_range(0, 15) == 0) ? AW'(W + $urandom_range(0, 100)) : AW'($urandom_range(0, W - 1));
          p0d = DW'($urandom);
        end
        if (!p1v && $urandom_range(0, 9) < 6) begin
          p1v = 1;
          p1a = ($urandom_range(0, 15) == 0) ? AW'(W + $urandom_range(0, 100)) : AW'($urandom_range(0, W - 1));
          p1d = DW'($urandom);
        end
        cs = ($urandom_range(0, 1499) == 0);
        cc = DW'($urandom);
        drive(p0v, p0a, p0d, p1v, p1a, p1d, cs, cc);

        exp_r0 = 0; exp_r1 = 0; exp_ws = 0; exp_busy = 0; exp_wa = '0; exp_wd = '0;
        if (m_in_clear) begin
          exp_ws = 1; exp_wa = AW'(m_idx); exp_wd = m_color; exp_busy = 1;
          if (m_idx == W - 1) m_in_clear = 0;
          else m_idx++;
        end else if (cs) begin
          m_in_clear = 1; m_idx = 0; m_color = cc; exp_busy = 1;
        end else begin
          if (p0v && p1v) who = m_rr;
          else if (p0v)   who = 0;
          else if (p1v)   who = 1;
          else            who = -1;
          if (who >= 0) begin
            m_rr = 1 - who;
            exp_r0 = (who == 0);
            exp_r1 = (who == 1);
            if (int'(who == 0 ? p0a : p1a) < W) begin
              exp_ws = 1;
              exp_wa = (who == 0) ? p0a : p1a;
              exp_wd = (who == 0) ? p0d : p1d;
            end else begin
              m_err = 1;
            end
          end
        end

        settle();
        check("rnd_req0_ready", 32'(bus.req0_ready), 32'(exp_r0));
        check("rnd_req1_ready", 32'(bus.req1_ready), 32'(exp_r1));
        if (exp_r0) p0v = 0;
        if (exp_r1) p1v = 0;
        tick();
        check("rnd_write_signal", 32'(bus.write_signal), 32'(exp_ws));
        check("rnd_clear_busy", 32'(bus.clear_busy), 32'(exp_busy));
        check("rnd_addr_error", 32'(bus.addr_error), 32'(m_err));
        if (exp_ws) begin
          check("rnd_write_address", 32'(bus.write_address), 32'(exp_wa));
          check("rnd_write_data", 32'(bus.write_data), 32'(exp_wd));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_write_arbiter.md
Name: framebuffer_write_arbiter

Overview:
- Shares the single 8-bit framebuffer write port (write_signal/write_address/write_data) between two requesters: req0 (application/Gigatron video writer) and req1 (test pattern generator or debug writer).
- Adds a built-in clear engine that fills the whole framebuffer with one color value.
- Sits between the writers and the framebuffer write port, in the write-clock domain.

Parameters:
- ADDR_WIDTH, 19, framebuffer address width.
- DATA_WIDTH, 8, pixel width (8-bit color).
- FB_WORDS, 307200, number of valid framebuffer locations (640x480); legal addresses are 0..FB_WORDS-1.

Ports:
- vga_clock  input  1  sole clock; all logic on posedge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  req0 has a write pending.
- req0_ready  output  1  req0 write accepted this cycle (combinational).
- req0_address  input  ADDR_WIDTH  req0 target address.
- req0_data  input  DATA_WIDTH  req0 pixel value.
- req1_valid, req1_ready, req1_address, req1_data: same as req0, for requester 1.
- clear_start  input  1  single-cycle pulse that starts a full-frame clear.
- clear_color  input  DATA_WIDTH  fill value, sampled at clear_start.
- clear_busy  output  1  clear in progress.
- addr_error  output  1  sticky flag: a request had address >= FB_WORDS.
- write_signal  output  1  framebuffer write strobe (registered).
- write_address  output  ADDR_WIDTH  framebuffer address (registered).
- write_data  output  DATA_WIDTH  framebuffer data (registered).

Behaviour:
- Reset values (async assert, sync release): state=IDLE, write_signal=0, write_address=0, write_data=0, clear_busy=0, addr_error=0, rr_ptr=0 (req0 favoured), clear counter=0.
- Reset mid-clear aborts the clear immediately; no further writes are issued.
- States are IDLE and CLEAR.

IDLE:
- If clear_start=1:
  - Both readies are 0 this cycle; clear wins over any valid request.
  - Latch clear_color, go to CLEAR, counter=0.
- Otherwise grant as follows:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant req[rr_ptr].
  - After any grant to requester i, rr_ptr <= ~i. rr_ptr is unchanged when there is no grant.
- Transfer happens when valid & ready. The next cycle outputs write_signal=1 and write_address/write_data equal to the granted request's values.
- Latency is 1 cycle. Throughput is 1 write per cycle; back-to-back grants are allowed.
- No transfer: write_signal=0 next cycle; write_address/write_data hold their last values.
- Requesters must hold address/data stable while valid & !ready.
- Accepted request with address >= FB_WORDS:
  - Handshake completes (ready=1).
  - write_signal stays 0 next cycle.
  - addr_error <= 1 and stays set until reset.
  - Still counts as a grant for rr_ptr.

CLEAR:
- req0_ready=req1_ready=0.
- Each cycle the registered outputs carry write_signal=1, write_address=counter, write_data=latched color; then counter++.
- Writes occupy exactly FB_WORDS consecutive cycles, addresses 0..FB_WORDS-1 ascending.
- After the cycle that issues address FB_WORDS-1, return to IDLE. The next cycle write_signal=0 unless a request is granted in that first IDLE cycle.
- clear_busy=1 from the cycle after clear_start through the cycle write_address=FB_WORDS-1 is output; 0 otherwise.
- clear_start during CLEAR is ignored; the clear is not restarted and the color is not re-latched.
- A clear_color change during CLEAR has no effect.

Width rules:
- Counter is ADDR_WIDTH bits and never wraps; termination is by compare to FB_WORDS-1.
- Address range checks are unsigned.

Test Plan:
- Reset then single req0 write, addr=0x00010, data=0xA5 -> req0_ready=1 same cycle; next cycle write_signal=1, write_address=0x00010, write_data=0xA5; following cycle write_signal=0.
- req0 and req1 both valid continuously for 6 cycles after reset (addr 1/2, data 0x11/0x22) -> grants alternate 0,1,0,1,0,1; six consecutive write cycles with matching address/data.
- clear_start with clear_color=0x3C while req1_valid=1 -> req1_ready=0 for FB_WORDS+1 cycles; exactly 307200 writes, addresses 0..307199 ascending, all data 0x3C; clear_busy falls after address 307199; req1 granted on the first IDLE cycle.
- Second clear_start pulse at address 1000 of a running clear with clear_color=0xFF -> ignored; data stays 0x3C; total write count is still 307200.
- req0 addr=307200, data=0x01 -> req0_ready=1, no write_signal, addr_error=1 and sticky; a subsequent legal write to addr 5 proceeds normally with addr_error still 1.
- reset_n asserted at clear address 500 -> write_signal, clear_busy and addr_error drop to 0 asynchronously; after release, state is IDLE and a req1 write to addr 7 completes in 1 cycle.
